// File: rtl/ebox_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// ebox_pkg
//   Shared EBOX types: DRAM word layout, diag load function codes and the
//   DRAM loader commit-sequence states.
//   Revision: 1.0
// ============================================================================
package ebox_pkg;

    localparam int DRAM_WORD_W    = 15;
    localparam int DRAM_PAYLOAD_W = 14;

    // Field order gives word bits [0:14] = A, B, PAR, J[1:4], J[7:10].
    typedef struct packed {
        logic [0:2] A;
        logic [0:2] B;
        logic       PAR;
        logic [0:3] J1_4;
        logic [0:3] J7_10;
    } dramWord_t;

    localparam logic [2:0] DRAMLD_AB_EVEN    = 3'd0;
    localparam logic [2:0] DRAMLD_AB_ODD     = 3'd1;
    localparam logic [2:0] DRAMLD_J1_4       = 3'd2;
    localparam logic [2:0] DRAMLD_J7_10_EVEN = 3'd3;
    localparam logic [2:0] DRAMLD_J7_10_ODD  = 3'd4;
    localparam logic [2:0] DRAMLD_ADDR_HI    = 3'd5;
    localparam logic [2:0] DRAMLD_ADDR_LO    = 3'd6;
    localparam logic [2:0] DRAMLD_COMMIT     = 3'd7;

    typedef enum logic [2:0] {
        DL_IDLE = 3'd0,
        DL_WR_E = 3'd1,
        DL_WR_O = 3'd2,
        DL_RD_E = 3'd3,
        DL_CK_E = 3'd4,
        DL_CK_O = 3'd5
    } dramLdState_t;

    function automatic dramWord_t dram_pack(input logic [0:5] ab,
                                            input logic [0:3] j14,
                                            input logic [0:3] j7,
                                            input logic       par);
        dramWord_t w;
        w.A     = ab[0:2];
        w.B     = ab[3:5];
        w.PAR   = par;
        w.J1_4  = j14;
        w.J7_10 = j7;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_parity_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dram_parity_gen
//   Parity bit for a DRAM word given its 14 non-parity bits.
//   Revision: 1.0
// ============================================================================
module dram_parity_gen
    import ebox_pkg::*;
#(
    parameter int PAYLOAD_W = DRAM_PAYLOAD_W
) (
    input  logic [0:PAYLOAD_W-1] payload_i,
    output logic                 par_o
);

    // Odd parity: PAR makes the XOR across the whole word equal 1.
    assign par_o = ~(^payload_i);

endmodule
`default_nettype wire

// File: rtl/dram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dram_loader
//   Diagnostic writer for the dispatch RAM: stages an even/odd word pair from
//   load functions 060-067, writes both words, then reads back and verifies.
//   Revision: 1.0
// ============================================================================
module dram_loader
    import ebox_pkg::*;
#(
    parameter int DRAM_WIDTH     = 15,
    parameter int DRAM_ADDR_BITS = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      diagStrobe,
    input  logic [4:6]                diagFunc,
    input  logic [0:5]                ebusData,
    input  logic                      autoInc,
    output logic [0:DRAM_ADDR_BITS-1] memAddr,
    output logic [0:DRAM_WIDTH-1]     memDin,
    output logic                      memWe,
    input  logic [0:DRAM_WIDTH-1]     memDout,
    output logic                      busy,
    output logic                      done,
    output logic                      verifyErr,
    output logic                      overrun,
    output logic [0:DRAM_ADDR_BITS-2] pairAddr
);

    localparam int PAIR_W = DRAM_ADDR_BITS - 1;

    dramLdState_t              state_q, state_d;
    logic [0:5]                evenAB_q, evenAB_d;
    logic [0:5]                oddAB_q, oddAB_d;
    logic [0:3]                j14_q, j14_d;
    logic [0:3]                evenJ7_q, evenJ7_d;
    logic [0:3]                oddJ7_q, oddJ7_d;
    logic [0:PAIR_W-1]         pairAddr_q, pairAddr_d;
    logic [0:DRAM_ADDR_BITS-1] memAddr_q, memAddr_d;
    logic [0:DRAM_WIDTH-1]     memDin_q, memDin_d;
    logic                      memWe_q, memWe_d;
    logic                      done_q, done_d;
    logic                      verifyErr_q, verifyErr_d;
    logic                      overrun_q, overrun_d;

    logic                      evenPar, oddPar;
    dramWord_t                 evenWord, oddWord;
    logic                      accept, start;
    logic [0:PAIR_W-1]         pairBase;

    dram_parity_gen #(.PAYLOAD_W(DRAM_PAYLOAD_W)) u_par_even (
        .payload_i ({evenAB_q, j14_q, evenJ7_q}),
        .par_o     (evenPar)
    );

    dram_parity_gen #(.PAYLOAD_W(DRAM_PAYLOAD_W)) u_par_odd (
        .payload_i ({oddAB_q, j14_q, oddJ7_q}),
        .par_o     (oddPar)
    );

    assign evenWord = dram_pack(evenAB_q, j14_q, evenJ7_q, evenPar);
    assign oddWord  = dram_pack(oddAB_q, j14_q, oddJ7_q, oddPar);

    // The final check cycle also accepts a strobe so commits can run back to back.
    assign accept = diagStrobe && ((state_q == DL_IDLE) || (state_q == DL_CK_O));
    assign start  = accept && (diagFunc == DRAMLD_COMMIT);

    always_comb begin
        state_d     = state_q;
        evenAB_d    = evenAB_q;
        oddAB_d     = oddAB_q;
        j14_d       = j14_q;
        evenJ7_d    = evenJ7_q;
        oddJ7_d     = oddJ7_q;
        memAddr_d   = memAddr_q;
        memDin_d    = memDin_q;
        memWe_d     = 1'b0;
        done_d      = 1'b0;
        verifyErr_d = verifyErr_q;
        overrun_d   = overrun_q;

        pairBase = pairAddr_q;
        if ((state_q == DL_CK_O) && autoInc) begin
            pairBase = pairAddr_q + 1'b1;
        end
        pairAddr_d = pairBase;

        if (accept) begin
            case (diagFunc)
                DRAMLD_AB_EVEN:    evenAB_d         = ebusData;
                DRAMLD_AB_ODD:     oddAB_d          = ebusData;
                DRAMLD_J1_4:       j14_d            = ebusData[2:5];
                DRAMLD_J7_10_EVEN: evenJ7_d         = ebusData[2:5];
                DRAMLD_J7_10_ODD:  oddJ7_d          = ebusData[2:5];
                DRAMLD_ADDR_HI:    pairAddr_d[0:5]  = ebusData;
                DRAMLD_ADDR_LO:    pairAddr_d[6:7]  = ebusData[4:5];
                default:           ;
            endcase
        end

        if (diagStrobe && !accept) begin
            overrun_d = 1'b1;
        end
        if (start) begin
            verifyErr_d = 1'b0;
            if (state_q == DL_IDLE) begin
                overrun_d = 1'b0;
            end
        end

        // memAddr_d is the address presented during the following state.
        case (state_q)
            DL_WR_E: begin
                state_d   = DL_WR_O;
                memAddr_d = {pairAddr_q, 1'b1};
                memDin_d  = oddWord;
                memWe_d   = 1'b1;
            end
            DL_WR_O: begin
                state_d   = DL_RD_E;
                memAddr_d = {pairAddr_q, 1'b0};
            end
            DL_RD_E: begin
                state_d   = DL_CK_E;
                memAddr_d = {pairAddr_q, 1'b1};
            end
            DL_CK_E: begin
                state_d = DL_CK_O;
                done_d  = 1'b1;
                if (memDout != evenWord) begin
                    verifyErr_d = 1'b1;
                end
            end
            DL_CK_O: begin
                // A mismatch on the outgoing pair wins over a same-cycle restart's clear.
                state_d = DL_IDLE;
                if (memDout != oddWord) begin
                    verifyErr_d = 1'b1;
                end
            end
            default: state_d = DL_IDLE;
        endcase

        if (start) begin
            state_d   = DL_WR_E;
            memAddr_d = {pairBase, 1'b0};
            memDin_d  = evenWord;
            memWe_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DL_IDLE;
            evenAB_q    <= '0;
            oddAB_q     <= '0;
            j14_q       <= '0;
            evenJ7_q    <= '0;
            oddJ7_q     <= '0;
            pairAddr_q  <= '0;
            memAddr_q   <= '0;
            memDin_q    <= '0;
            memWe_q     <= 1'b0;
            done_q      <= 1'b0;
            verifyErr_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            evenAB_q    <= evenAB_d;
            oddAB_q     <= oddAB_d;
            j14_q       <= j14_d;
            evenJ7_q    <= evenJ7_d;
            oddJ7_q     <= oddJ7_d;
            pairAddr_q  <= pairAddr_d;
            memAddr_q   <= memAddr_d;
            memDin_q    <= memDin_d;
            memWe_q     <= memWe_d;
            done_q      <= done_d;
            verifyErr_q <= verifyErr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign memAddr   = memAddr_q;
    assign memDin    = memDin_q;
    assign memWe     = memWe_q;
    assign busy      = (state_q != DL_IDLE);
    assign done      = done_q;
    assign verifyErr = verifyErr_q;
    assign overrun   = overrun_q;
    assign pairAddr  = pairAddr_q;

endmodule
`default_nettype wire

// File: tb/tb_dram_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_dram_loader
//   Self-checking bench for dram_loader with a synchronous RAM model.
//   Revision: 1.0
// ============================================================================
module tb_dram_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        diagStrobe;
    logic [4:6]  diagFunc;
    logic [0:5]  ebusData;
    logic        autoInc;
    logic [0:8]  memAddr;
    logic [0:14] memDin;
    logic        memWe;
    logic [0:14] memDout;
    logic        busy, done, verifyErr, overrun;
    logic [0:7]  pairAddr;

    logic [0:13] pgIn;
    logic        pgOut;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mEvenAB, mOddAB, mJ14, mEvenJ7, mOddJ7, mPair;
    bit mVerr, mOvr;

    logic [0:14] ram [0:511];
    logic        corruptOdd = 1'b0;
    localparam logic [0:14] FLIP6 = 15'b000000100000000;

    dram_loader #(.DRAM_WIDTH(15), .DRAM_ADDR_BITS(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .diagStrobe (diagStrobe),
        .diagFunc   (diagFunc),
        .ebusData   (ebusData),
        .autoInc    (autoInc),
        .memAddr    (memAddr),
        .memDin     (memDin),
        .memWe      (memWe),
        .memDout    (memDout),
        .busy       (busy),
        .done       (done),
        .verifyErr  (verifyErr),
        .overrun    (overrun),
        .pairAddr   (pairAddr)
    );

    dram_parity_gen #(.PAYLOAD_W(14)) u_pg (.payload_i(pgIn), .par_o(pgOut));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memWe) ram[memAddr] <= memDin;
        memDout <= ram[memAddr] ^ ((corruptOdd && memAddr[8]) ? FLIP6 : 15'd0);
    end

    function automatic logic [0:14] mword(input int ab, input int j14, input int j7);
        int ones, par;
        ones = $countones(ab & 63) + $countones(j14 & 15) + $countones(j7 & 15);
        par  = (ones % 2 == 0) ? 1 : 0;
        return 15'(((ab & 63) << 9) | (par << 8) | ((j14 & 15) << 4) | (j7 & 15));
    endfunction

    task automatic model_reset();
        mEvenAB = 0; mOddAB = 0; mJ14 = 0; mEvenJ7 = 0; mOddJ7 = 0; mPair = 0;
        mVerr = 0; mOvr = 0;
    endtask

    task automatic strobe(input int f, input int d);
        @(negedge clk);
        diagStrobe = 1'b1;
        diagFunc   = f[2:0];
        ebusData   = d[5:0];
        @(negedge clk);
        diagStrobe = 1'b0;
        case (f)
            0: mEvenAB = d & 63;
            1: mOddAB  = d & 63;
            2: mJ14    = d & 15;
            3: mEvenJ7 = d & 15;
            4: mOddJ7  = d & 15;
            5: mPair   = (mPair & 3) | ((d & 63) << 2);
            6: mPair   = (mPair & 252) | (d & 3);
            default: ;
        endcase
    endtask

    task automatic run_commit(input string tag, input int injK, input int injData,
                              input bit expErr, input bit chained, input bit chainNext);
        int base;
        logic [5:0] we, dn, bs, expWe, expBs;
        logic [0:14] evW, odW, din0, din1;
        logic [0:8] a0, a1;
        base = mPair;
        evW  = mword(mEvenAB, mJ14, mEvenJ7);
        odW  = mword(mOddAB, mJ14, mOddJ7);
        din0 = '0; din1 = '0; a0 = '0; a1 = '0;
        if (!chained) begin
            @(negedge clk);
            diagStrobe = 1'b1; diagFunc = 3'd7; ebusData = '0;
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0 || !chained) @(negedge clk);
            we[k] = memWe; dn[k] = done; bs[k] = busy;
            if (k == 0) begin
                din0 = memDin; a0 = memAddr;
                checks++;
                if (verifyErr !== 1'b0 || (!chained && overrun !== 1'b0)) begin
                    errors++;
                    $display("FAIL %s_start_clear: verifyErr=%b overrun=%b expected 0", tag, verifyErr, overrun);
                end
            end
            if (k == 1) begin din1 = memDin; a1 = memAddr; end
            diagStrobe = (k == injK - 1);
            if (k == injK - 1) begin diagFunc = 3'd0; ebusData = injData[5:0]; end
            if (chainNext && k == 4) begin diagStrobe = 1'b1; diagFunc = 3'd7; ebusData = '0; end
        end
        if (!chainNext) diagStrobe = 1'b0;

        mVerr = expErr;
        if (injK > 0) mOvr = 1;
        else if (!chained) mOvr = 0;
        if (autoInc) mPair = (mPair + 1) & 255;

        expWe = chainNext ? 6'b100011 : 6'b000011;
        expBs = chainNext ? 6'b111111 : 6'b011111;
        checks++;
        if (we !== expWe || dn !== 6'b010000 || bs !== expBs) begin
            errors++;
            $display("FAIL %s_timing: we/done/busy got %b/%b/%b expected %b/%b/%b",
                     tag, we, dn, bs, expWe, 6'b010000, expBs);
        end
        checks++;
        if (din0 !== evW || din1 !== odW || a0 !== 9'(base * 2) || a1 !== 9'(base * 2 + 1)) begin
            errors++;
            $display("FAIL %s_write: din %h/%h addr %h/%h expected %h/%h %h/%h",
                     tag, din0, din1, a0, a1, evW, odW, 9'(base * 2), 9'(base * 2 + 1));
        end
        checks++;
        if (ram[base * 2] !== evW || ram[base * 2 + 1] !== odW) begin
            errors++;
            $display("FAIL %s_ram: got %h/%h expected %h/%h", tag, ram[base * 2], ram[base * 2 + 1], evW, odW);
        end
        checks++;
        if (verifyErr !== mVerr || overrun !== mOvr || pairAddr !== 8'(mPair)) begin
            errors++;
            $display("FAIL %s_status: verifyErr=%b overrun=%b pairAddr=%h expected %b %b %h",
                     tag, verifyErr, overrun, pairAddr, mVerr, mOvr, 8'(mPair));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; diagStrobe = 1'b0; diagFunc = '0; ebusData = '0; autoInc = 1'b0; pgIn = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({memAddr, memDin, memWe, busy, done, verifyErr, overrun, pairAddr} !== '0) begin
            errors++;
            $display("FAIL reset_values: got addr=%h din=%h we=%b busy=%b done=%b ve=%b ov=%b pair=%h expected all 0",
                     memAddr, memDin, memWe, busy, done, verifyErr, overrun, pairAddr);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_commit();
        run_commit("zero", -1, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ram[0] !== 15'b000000100000000 || ram[1] !== 15'b000000100000000) begin
            errors++;
            $display("FAIL zero_literal: got %b/%b expected 000000100000000", ram[0], ram[1]);
        end
    endtask

    task automatic test_pattern();
        strobe(0, 'o52); strobe(1, 'o25); strobe(2, 'o17); strobe(3, 'o05);
        strobe(4, 'o12); strobe(5, 'o77); strobe(6, 'o03);
        run_commit("pattern", -1, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ram['o776] !== 15'b101010011110101 || ram['o777] !== 15'b010101011111010 || pairAddr !== 8'hFF) begin
            errors++;
            $display("FAIL pattern_literal: got %b/%b pair=%h expected 101010011110101/010101011111010 ff",
                     ram['o776], ram['o777], pairAddr);
        end
    endtask

    task automatic test_autoinc_wrap();
        autoInc = 1'b1;
        run_commit("wrap", -1, 0, 1'b0, 1'b0, 1'b0);
        autoInc = 1'b0;
        checks++;
        if (pairAddr !== 8'h00) begin
            errors++;
            $display("FAIL wrap_pair: got %h expected 00", pairAddr);
        end
    endtask

    task automatic test_verify_err();
        strobe(5, 'o12);
        corruptOdd = 1'b1;
        run_commit("verr_bad", -1, 0, 1'b1, 1'b0, 1'b0);
        corruptOdd = 1'b0;
        run_commit("verr_clear", -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        strobe(0, 'o31);
        run_commit("overrun", 2, 'o44, 1'b0, 1'b0, 1'b0);
        run_commit("overrun_clear", -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        autoInc = 1'b1;
        run_commit("b2b_first", -1, 0, 1'b0, 1'b0, 1'b1);
        run_commit("b2b_second", -1, 0, 1'b0, 1'b1, 1'b0);
        autoInc = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int nf;
            nf = int'($urandom_range(1, 5));
            for (int i = 0; i < nf; i++) begin
                strobe(int'($urandom_range(0, 6)), int'($urandom_range(0, 63)));
            end
            autoInc = 1'($urandom_range(0, 1));
            run_commit("random", -1, 0, 1'b0, 1'b0, 1'b0);
        end
        autoInc = 1'b0;
    endtask

    task automatic test_parity_gen();
        for (int i = 0; i < 6; i++) begin
            pgIn = 14'($urandom);
            #1;
            checks++;
            if (pgOut !== (($countones(pgIn) % 2) == 0)) begin
                errors++;
                $display("FAIL parity_gen: in=%b got %b expected %b", pgIn, pgOut, (($countones(pgIn) % 2) == 0));
            end
        end
    endtask

    task automatic test_reset_midcommit();
        strobe(5, 'o21); strobe(0, 'o63); strobe(2, 'o11);
        @(negedge clk);
        diagStrobe = 1'b1; diagFunc = 3'd7; ebusData = '0;
        @(negedge clk);
        diagStrobe = 1'b0;
        @(negedge clk);
        checks++;
        if (memWe !== 1'b1) begin
            errors++;
            $display("FAIL midreset_wr_o: memWe=%b expected 1", memWe);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({memAddr, memDin, memWe, busy, done, verifyErr, overrun, pairAddr} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got addr=%h din=%h we=%b busy=%b done=%b ve=%b ov=%b pair=%h expected all 0",
                     memAddr, memDin, memWe, busy, done, verifyErr, overrun, pairAddr);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        run_commit("after_reset", -1, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_commit();
        test_pattern();
        test_autoinc_wrap();
        test_verify_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_parity_gen();
        test_reset_midcommit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
